// File: rtl/cpu_bus_responder_if.sv
// CPU external bus and transducer-table RAM port seen by the responder.
// The responder takes the slave side; the CPU/RAM environment the master side.
interface cpu_bus_responder_if #(
  parameter int RAM_AW = 14
);
  logic [15:0]       CPU_ADDR;
  logic [15:0]       CPU_DATA_IN;
  logic [15:0]       CPU_DATA_OUT;
  logic              CPU_DATA_OE;
  logic              CPU_CS1_N;
  logic              CPU_WE0_N;
  logic              CPU_RD_N;
  logic              RAM_WE;
  logic              RAM_RE;
  logic [RAM_AW-1:0] RAM_ADDR;
  logic [15:0]       RAM_DIN;
  logic [15:0]       RAM_DOUT;

  modport slave (
    input  CPU_ADDR, CPU_DATA_IN,
    input  CPU_CS1_N, CPU_WE0_N, CPU_RD_N,
    input  RAM_DOUT,
    output CPU_DATA_OUT, CPU_DATA_OE,
    output RAM_WE, RAM_RE, RAM_ADDR, RAM_DIN
  );

  modport master (
    output CPU_ADDR, CPU_DATA_IN,
    output CPU_CS1_N, CPU_WE0_N, CPU_RD_N,
    output RAM_DOUT,
    input  CPU_DATA_OUT, CPU_DATA_OE,
    input  RAM_WE, RAM_RE, RAM_ADDR, RAM_DIN
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: synchronizes CPU strobes, decodes cycles, and serves a
// small control register bank plus the transducer-table RAM port.
module cpu_bus_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          RAM_AW      = 14,
  parameter logic [15:0] VERSION     = 16'h0010
) (
  input  logic                 CLK,
  input  logic                 RESET,
  cpu_bus_responder_if.slave   bus,
  output logic [12:0]          STEP,
  output logic                 SILENT_EN,
  output logic                 FORCE_FAN,
  output logic [3:0]           GPIO,
  output logic                 PROTO_ERR
);

  typedef enum logic [2:0] {
    IDLE, WR_CAPT, WR_WAIT, RD_REQ, RD_WAIT, RD_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sq, we_sq, rd_sq;
  logic cs_s, we_s, rd_s;

  logic              bank_q, bank_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [12:0]       step_q, step_d;
  logic [3:0]        gpio_q, gpio_d;
  logic              perr_q, perr_d;
  logic              ram_we_q, ram_we_d;
  logic              hold_q, hold_d;
  logic [15:0]       reg_rd;

  assign cs_s = cs_sq[SYNC_STAGES-1];
  assign we_s = we_sq[SYNC_STAGES-1];
  assign rd_s = rd_sq[SYNC_STAGES-1];

  always_comb begin
    reg_rd = 16'h0000;
    case (addr_q[2:0])
      3'd0:    reg_rd = {14'h0, ctrl_q};
      3'd1:    reg_rd = {3'h0, step_q};
      3'd2:    reg_rd = {12'h0, gpio_q};
      3'd3:    reg_rd = VERSION;
      default: reg_rd = 16'h0000;
    endcase
  end

  // hold_q blocks a new cycle until both strobes have returned high,
  // so each strobe pulse yields exactly one transaction.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ctrl_d   = ctrl_q;
    step_d   = step_q;
    gpio_d   = gpio_q;
    perr_d   = perr_q;
    ram_we_d = 1'b0;
    hold_d   = hold_q;
    if (hold_q && we_s && rd_s) hold_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s && !hold_q) begin
          if (!we_s && !rd_s) begin
            perr_d = 1'b1;
            hold_d = 1'b1;
          end else if (!we_s) begin
            state_d = WR_CAPT;
          end else if (!rd_s) begin
            state_d = RD_REQ;
          end
        end
      end
      WR_CAPT: begin
        bank_d  = bus.CPU_ADDR[15];
        addr_d  = bus.CPU_ADDR[RAM_AW-1:0];
        wdata_d = bus.CPU_DATA_IN;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (cs_s) begin
          perr_d  = 1'b1;
          hold_d  = 1'b1;
          state_d = IDLE;
        end else if (we_s) begin
          hold_d  = 1'b1;
          state_d = IDLE;
          if (bank_q) begin
            ram_we_d = 1'b1;
          end else begin
            case (addr_q[2:0])
              3'd0: begin
                ctrl_d = wdata_q[1:0];
                if (wdata_q[15]) perr_d = 1'b0;
              end
              3'd1:    step_d = wdata_q[12:0];
              3'd2:    gpio_d = wdata_q[3:0];
              default: ;
            endcase
          end
        end
      end
      RD_REQ: begin
        bank_d  = bus.CPU_ADDR[15];
        addr_d  = bus.CPU_ADDR[RAM_AW-1:0];
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = bank_q ? bus.RAM_DOUT : reg_rd;
        state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_s || cs_s) begin
          hold_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cs_sq    <= '1;
      we_sq    <= '1;
      rd_sq    <= '1;
      bank_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ctrl_q   <= '0;
      step_q   <= '0;
      gpio_q   <= '0;
      perr_q   <= 1'b0;
      ram_we_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_sq    <= {cs_sq[SYNC_STAGES-2:0], bus.CPU_CS1_N};
      we_sq    <= {we_sq[SYNC_STAGES-2:0], bus.CPU_WE0_N};
      rd_sq    <= {rd_sq[SYNC_STAGES-2:0], bus.CPU_RD_N};
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ctrl_q   <= ctrl_d;
      step_q   <= step_d;
      gpio_q   <= gpio_d;
      perr_q   <= perr_d;
      ram_we_q <= ram_we_d;
      hold_q   <= hold_d;
    end
  end

  // RAM read is issued straight from the pins so data lands in RD_WAIT.
  assign bus.RAM_RE   = (state_q == RD_REQ) && bus.CPU_ADDR[15];
  assign bus.RAM_ADDR = (state_q == RD_REQ) ?
                        bus.CPU_ADDR[RAM_AW-1:0] : addr_q;
  assign bus.RAM_DIN  = wdata_q;
  assign bus.RAM_WE   = ram_we_q;

  assign bus.CPU_DATA_OUT = rdata_q;
  assign bus.CPU_DATA_OE  = (state_q == RD_HOLD) && !rd_s && !cs_s;

  assign STEP      = step_q;
  assign SILENT_EN = ctrl_q[1];
  assign FORCE_FAN = ctrl_q[0];
  assign GPIO      = gpio_q;
  assign PROTO_ERR = perr_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: vector table, RAM model, read/write scoreboards
// and hand-built latency, protocol-error and reset sequences.
module tb_cpu_bus_responder;
  localparam int SYNC = 2;
  localparam int AW   = 14;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [12:0] STEP;
  logic        SILENT_EN, FORCE_FAN, PROTO_ERR;
  logic [3:0]  GPIO;

  cpu_bus_responder_if #(.RAM_AW(AW)) bus ();

  cpu_bus_responder #(
    .SYNC_STAGES(SYNC), .RAM_AW(AW), .VERSION(16'h0010)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave),
    .STEP(STEP), .SILENT_EN(SILENT_EN), .FORCE_FAN(FORCE_FAN),
    .GPIO(GPIO), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // 1-cycle-latency RAM model
  logic [15:0] mem [0:63];
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem[7] <= 16'hABCD;
    end else begin
      if (bus.RAM_WE) mem[bus.RAM_ADDR[5:0]] <= bus.RAM_DIN;
      if (bus.RAM_RE) bus.RAM_DOUT <= mem[bus.RAM_ADDR[5:0]];
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wexp_t;

  logic [15:0] rq [$];
  wexp_t       wq [$];
  int we_cycles = 0, re_cycles = 0, oe_cycles = 0;
  logic oe_prev = 1'b0;

  always @(negedge CLK) begin
    if (bus.RAM_WE) begin
      we_cycles++;
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL ram_we: unexpected pulse addr %h", bus.RAM_ADDR);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        chk("ram_waddr", 16'(bus.RAM_ADDR), 16'(e.a));
        chk("ram_din", bus.RAM_DIN, e.d);
      end
    end
    if (bus.RAM_RE) re_cycles++;
    if (bus.CPU_DATA_OE) oe_cycles++;
    if (bus.CPU_DATA_OE && !oe_prev) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_oe: unexpected OE, data %h", bus.CPU_DATA_OUT);
      end else begin
        chk("rd_data", bus.CPU_DATA_OUT, rq.pop_front());
      end
    end
    oe_prev = bus.CPU_DATA_OE;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    if (a[15]) wq.push_back('{a[AW-1:0], d});
    bus.CPU_ADDR = a; bus.CPU_DATA_IN = d; bus.CPU_CS1_N = 1'b0;
    cyc(2); bus.CPU_WE0_N = 1'b0;
    cyc(SYNC + 4); bus.CPU_WE0_N = 1'b1;
    cyc(SYNC + 3); bus.CPU_CS1_N = 1'b1;
    cyc(4);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp);
    rq.push_back(exp);
    bus.CPU_ADDR = a; bus.CPU_CS1_N = 1'b0;
    cyc(2); bus.CPU_RD_N = 1'b0;
    cyc(SYNC + 7); bus.CPU_RD_N = 1'b1;
    cyc(3); bus.CPU_CS1_N = 1'b1;
    cyc(4);
    chk("rd_done", 16'(rq.size()), 16'd0);
  endtask

  task automatic chk_regs(input string n, input logic [12:0] s,
                          input logic [3:0] g, input logic [1:0] c);
    chk({n, "_step"}, 16'(STEP), 16'(s));
    chk({n, "_gpio"}, 16'(GPIO), 16'(g));
    chk({n, "_ctrl"}, 16'({SILENT_EN, FORCE_FAN}), 16'(c));
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [12:0] step;
    logic [3:0]  gpio;
    logic [1:0]  ctrl;
  } vec_t;

  vec_t v [16];

  initial begin
    int we0, re0, oe0, k;
    v[0]  = '{1'b1, 16'h0001, 16'h0064, 13'd100,   4'h0, 2'd0};
    v[1]  = '{1'b0, 16'h0001, 16'h0064, 13'd100,   4'h0, 2'd0};
    v[2]  = '{1'b1, 16'h8005, 16'h09C4, 13'd100,   4'h0, 2'd0};
    v[3]  = '{1'b0, 16'h8005, 16'h09C4, 13'd100,   4'h0, 2'd0};
    v[4]  = '{1'b0, 16'h8007, 16'hABCD, 13'd100,   4'h0, 2'd0};
    v[5]  = '{1'b1, 16'h0003, 16'hFFFF, 13'd100,   4'h0, 2'd0};
    v[6]  = '{1'b1, 16'h0006, 16'hFFFF, 13'd100,   4'h0, 2'd0};
    v[7]  = '{1'b0, 16'h0003, 16'h0010, 13'd100,   4'h0, 2'd0};
    v[8]  = '{1'b0, 16'h0006, 16'h0000, 13'd100,   4'h0, 2'd0};
    v[9]  = '{1'b1, 16'h0002, 16'h000A, 13'd100,   4'hA, 2'd0};
    v[10] = '{1'b0, 16'h0002, 16'h000A, 13'd100,   4'hA, 2'd0};
    v[11] = '{1'b1, 16'h0000, 16'h0002, 13'd100,   4'hA, 2'd2};
    v[12] = '{1'b0, 16'h0000, 16'h0002, 13'd100,   4'hA, 2'd2};
    v[13] = '{1'b1, 16'h0001, 16'hFFFF, 13'h1FFF,  4'hA, 2'd2};
    v[14] = '{1'b0, 16'h0001, 16'h1FFF, 13'h1FFF,  4'hA, 2'd2};
    v[15] = '{1'b1, 16'h8000, 16'h5A5A, 13'h1FFF,  4'hA, 2'd2};

    RESET = 1'b1;
    bus.CPU_CS1_N = 1'b1; bus.CPU_WE0_N = 1'b1; bus.CPU_RD_N = 1'b1;
    bus.CPU_ADDR = 16'h0; bus.CPU_DATA_IN = 16'h0;
    cyc(4);
    @(negedge CLK);
    chk_regs("reset", 13'd0, 4'h0, 2'd0);
    chk("reset_perr", 16'(PROTO_ERR), 16'd0);
    chk("reset_oe", 16'(bus.CPU_DATA_OE), 16'd0);
    chk("reset_dout", bus.CPU_DATA_OUT, 16'h0);
    chk("reset_ramwe", 16'(bus.RAM_WE), 16'd0);
    @(posedge CLK); #1 RESET = 1'b0;
    cyc(3);

    for (int i = 0; i < 16; i++) begin
      we0 = we_cycles; re0 = re_cycles;
      if (v[i].wr) bus_write(v[i].a, v[i].d);
      else         bus_read(v[i].a, v[i].d);
      chk_regs($sformatf("vec%0d", i), v[i].step, v[i].gpio, v[i].ctrl);
      chk($sformatf("vec%0d_we", i), 16'(we_cycles - we0),
          16'((v[i].wr && v[i].a[15]) ? 1 : 0));
      chk($sformatf("vec%0d_re", i), 16'(re_cycles - re0),
          16'((!v[i].wr && v[i].a[15]) ? 1 : 0));
      chk($sformatf("vec%0d_perr", i), 16'(PROTO_ERR), 16'd0);
    end

    // commit lands exactly one cycle after the synced WE rise
    bus.CPU_ADDR = 16'h0001; bus.CPU_DATA_IN = 16'h0123;
    bus.CPU_CS1_N = 1'b0;
    cyc(2); bus.CPU_WE0_N = 1'b0;
    cyc(SYNC + 4); bus.CPU_WE0_N = 1'b1;
    repeat (SYNC + 1) @(negedge CLK);
    chk("wlat_before", 16'(STEP), 16'h1FFF);
    @(negedge CLK);
    chk("wlat_after", 16'(STEP), 16'h0123);
    cyc(3); bus.CPU_CS1_N = 1'b1; cyc(4);

    // read data/OE appear SYNC+3 cycles after RD falls
    rq.push_back(16'h0123);
    bus.CPU_ADDR = 16'h0001; bus.CPU_CS1_N = 1'b0;
    cyc(2); bus.CPU_RD_N = 1'b0;
    repeat (SYNC + 3) @(negedge CLK);
    chk("rlat_before", 16'(bus.CPU_DATA_OE), 16'd0);
    @(negedge CLK);
    chk("rlat_oe", 16'(bus.CPU_DATA_OE), 16'd1);
    chk("rlat_data", bus.CPU_DATA_OUT, 16'h0123);
    cyc(3); bus.CPU_RD_N = 1'b1;
    repeat (SYNC + 1) @(negedge CLK);
    chk("rlat_drop", 16'(bus.CPU_DATA_OE), 16'd0);
    cyc(2); bus.CPU_CS1_N = 1'b1; cyc(4);

    // WE and RD low together
    we0 = we_cycles; oe0 = oe_cycles;
    bus.CPU_ADDR = 16'h0001; bus.CPU_DATA_IN = 16'h0777;
    bus.CPU_CS1_N = 1'b0;
    cyc(2); bus.CPU_WE0_N = 1'b0; bus.CPU_RD_N = 1'b0;
    cyc(SYNC + 6);
    chk("both_perr", 16'(PROTO_ERR), 16'd1);
    bus.CPU_WE0_N = 1'b1; bus.CPU_RD_N = 1'b1;
    cyc(SYNC + 3); bus.CPU_CS1_N = 1'b1; cyc(4);
    chk("both_step", 16'(STEP), 16'h0123);
    chk("both_oe", 16'(oe_cycles - oe0), 16'd0);
    chk("both_we", 16'(we_cycles - we0), 16'd0);

    bus_write(16'h0000, 16'h8003);
    chk("clr1_perr", 16'(PROTO_ERR), 16'd0);
    chk("clr1_fan", 16'(FORCE_FAN), 16'd1);
    chk("clr1_silent", 16'(SILENT_EN), 16'd1);

    // CS rises before WE: write aborted
    bus.CPU_ADDR = 16'h0001; bus.CPU_DATA_IN = 16'h0555;
    bus.CPU_CS1_N = 1'b0;
    cyc(2); bus.CPU_WE0_N = 1'b0;
    cyc(SYNC + 4); bus.CPU_CS1_N = 1'b1;
    cyc(SYNC + 3); bus.CPU_WE0_N = 1'b1;
    cyc(SYNC + 4);
    chk("abort_step", 16'(STEP), 16'h0123);
    chk("abort_perr", 16'(PROTO_ERR), 16'd1);

    bus_write(16'h0000, 16'h8003);
    chk("clr2_perr", 16'(PROTO_ERR), 16'd0);

    // reset while OE is driven
    rq.push_back(16'h000A);
    bus.CPU_ADDR = 16'h0002; bus.CPU_CS1_N = 1'b0;
    cyc(2); bus.CPU_RD_N = 1'b0;
    k = 0;
    while (!bus.CPU_DATA_OE && k < 20) begin
      @(negedge CLK); k++;
    end
    chk("rst_oe_seen", 16'(bus.CPU_DATA_OE), 16'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_oe", 16'(bus.CPU_DATA_OE), 16'd0);
    chk_regs("rst", 13'd0, 4'h0, 2'd0);
    chk("rst_dout", bus.CPU_DATA_OUT, 16'h0);
    chk("rst_perr", 16'(PROTO_ERR), 16'd0);
    bus.CPU_RD_N = 1'b1; bus.CPU_CS1_N = 1'b1;
    cyc(3);
    RESET = 1'b0;
    cyc(3);
    bus_read(16'h0003, 16'h0010);
    bus_read(16'h0002, 16'h0000);

    cyc(4);
    chk("wq_empty", 16'(wq.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
